// File: rtl/vga_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter_if
// Bundles every signal of the frame-buffer arbiter except the clock and reset.
//   Display read side : rd_req, rd_addr -> rd_data, rd_valid
//   Drawing write side: wr_req, wr_addr, wr_data -> wr_ready, wr_overflow
//   Clear control     : clr_req, clr_color, vs_n -> clr_busy
//   RAM port          : mem_addr, mem_wdata, mem_we -> mem_rdata
// Modports:
//   slave  - the arbiter itself
//   master - the environment (display, renderer, sync generator and RAM)
// ---------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
);
  logic              vs_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_overflow;
  logic              clr_req;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vs_n, rd_req, rd_addr, wr_req, wr_addr, wr_data,
           clr_req, clr_color, mem_rdata,
    output rd_data, rd_valid, wr_ready, wr_overflow, clr_busy,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output vs_n, rd_req, rd_addr, wr_req, wr_addr, wr_data,
           clr_req, clr_color, mem_rdata,
    input  rd_data, rd_valid, wr_ready, wr_overflow, clr_busy,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Owns the single address/data/write-enable port of the frame buffer.
// Display reads always win; queued drawing writes and the frame-synchronised
// clear engine use only the cycles the display leaves free.
// Ports:
//   iVGA_CLK - pixel clock, all state on rising edge
//   iRST_n   - asynchronous active-low reset
//   bus      - vga_fb_arbiter_if.slave (read, write queue, clear, RAM port)
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 12,
  parameter int FB_SIZE    = 4800,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_n,
  vga_fb_arbiter_if.slave      bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CLEAR} clr_state_t;

  clr_state_t        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] clr_color_q;
  logic              clr_busy_q;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_valid_q;
  logic              overflow_q;

  logic wr_ready;
  logic push, pop;
  logic clr_grant, drain_grant;

  // Priority: display read > clear write > queue drain.
  assign clr_grant   = !bus.rd_req && (state_q == S_CLEAR);
  assign drain_grant = !bus.rd_req && (state_q != S_CLEAR) && (count_q != '0);

  assign wr_ready = (count_q != FULL_CNT);
  assign push     = bus.wr_req && wr_ready;
  assign pop      = drain_grant;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // RAM port mux; idle cycles park the address at 0.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (bus.rd_req) begin
      bus.mem_addr = bus.rd_addr;
    end else if (clr_grant) begin
      bus.mem_addr  = clr_cnt_q;
      bus.mem_wdata = clr_color_q;
      bus.mem_we    = 1'b1;
    end else if (drain_grant) begin
      bus.mem_addr  = fifo_addr_q[rd_ptr_q];
      bus.mem_wdata = fifo_data_q[rd_ptr_q];
      bus.mem_we    = 1'b1;
    end
  end

  assign bus.rd_data     = bus.mem_rdata;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_ready    = wr_ready;
  assign bus.wr_overflow = overflow_q;
  assign bus.clr_busy    = clr_busy_q;

  // Queue storage carries no reset; emptiness is tracked by the pointers.
  always_ff @(posedge iVGA_CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= bus.rd_req;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.wr_req && !wr_ready) overflow_q <= 1'b1;
    end
  end

  // Clear engine. clr_busy is registered alongside the state so it rises the
  // cycle after clr_req and falls the cycle after the last clear write.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.clr_req) begin
            clr_color_q <= bus.clr_color;
            clr_busy_q  <= 1'b1;
            state_q     <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!bus.vs_n) begin
            clr_cnt_q <= '0;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // Display reads stall the counter; no wrap past the last pixel.
          if (clr_grant) begin
            if (clr_cnt_q == LAST_ADDR) begin
              clr_busy_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              clr_cnt_q <= clr_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 12;
  localparam int FB_SIZE = 4800;

  logic iVGA_CLK = 1'b0;
  logic iRST_n   = 1'b0;
  int checks   = 0;
  int failures = 0;
  int bad;

  always #5 iVGA_CLK = ~iVGA_CLK;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(FB_SIZE), .FIFO_DEPTH(8)
  ) dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .bus      (bus)
  );

  // Behavioural RAM: synchronous write, 1-cycle registered read.
  logic [DATA_W-1:0] ram [FB_SIZE];
  always @(posedge iVGA_CLK) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    for (int a = 0; a < FB_SIZE; a++) ram[a] = '0;
    bus.vs_n = 1'b1; bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0; bus.clr_color = '0;

    // Reset state
    repeat (2) @(negedge iVGA_CLK);
    #1;
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_wr_ready", 32'(bus.wr_ready), 1);
    check("rst_overflow", 32'(bus.wr_overflow), 0);
    check("rst_clr_busy", 32'(bus.clr_busy), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    @(negedge iVGA_CLK); iRST_n = 1'b1;

    // Read only
    ram[5] = 12'hABC;
    @(negedge iVGA_CLK); bus.rd_req = 1'b1; bus.rd_addr = 13'd5; #1;
    check("rd_mem_addr", 32'(bus.mem_addr), 5);
    check("rd_mem_we", 32'(bus.mem_we), 0);
    @(negedge iVGA_CLK); bus.rd_req = 1'b0; #1;
    check("rd_valid", 32'(bus.rd_valid), 1);
    check("rd_data", 32'(bus.rd_data), 32'hABC);
    @(negedge iVGA_CLK); #1;
    check("rd_valid_drop", 32'(bus.rd_valid), 0);

    // Write during 20 read cycles
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iVGA_CLK);
      bus.rd_req = 1'b1; bus.rd_addr = 13'd0;
      bus.wr_req = (i == 0); bus.wr_addr = 13'd10; bus.wr_data = 12'h0F0;
      #1;
      if (bus.mem_we !== 1'b0) bad++;
    end
    check("wdr_no_we_during_reads", 32'(bad), 0);
    @(negedge iVGA_CLK); bus.rd_req = 1'b0; bus.wr_req = 1'b0; #1;
    check("wdr_we", 32'(bus.mem_we), 1);
    check("wdr_addr", 32'(bus.mem_addr), 10);
    check("wdr_data", 32'(bus.mem_wdata), 32'h0F0);
    @(negedge iVGA_CLK); #1;
    check("wdr_we_after", 32'(bus.mem_we), 0);

    // Minimum push-to-write latency
    @(negedge iVGA_CLK); bus.wr_req = 1'b1; bus.wr_addr = 13'd11; bus.wr_data = 12'h555; #1;
    check("lat_push_cycle_we", 32'(bus.mem_we), 0);
    @(negedge iVGA_CLK); bus.wr_req = 1'b0; #1;
    check("lat_next_we", 32'(bus.mem_we), 1);
    check("lat_next_addr", 32'(bus.mem_addr), 11);
    @(negedge iVGA_CLK); #1;
    check("lat_idle_we", 32'(bus.mem_we), 0);
    check("ram_10", 32'(ram[10]), 32'h0F0);

    // FIFO full with reads blocking the drain
    for (int i = 0; i < 9; i++) begin
      @(negedge iVGA_CLK);
      bus.rd_req = 1'b1; bus.wr_req = 1'b1;
      bus.wr_addr = 13'(100 + i); bus.wr_data = 12'(12'h100 + i);
      #1;
      check($sformatf("full_wr_ready_%0d", i), 32'(bus.wr_ready), (i < 8) ? 1 : 0);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge iVGA_CLK); bus.rd_req = 1'b0; bus.wr_req = 1'b0; #1;
      if (j == 0) check("full_overflow", 32'(bus.wr_overflow), 1);
      check($sformatf("drain_we_%0d", j), 32'(bus.mem_we), 1);
      check($sformatf("drain_addr_%0d", j), 32'(bus.mem_addr), 100 + j);
      check($sformatf("drain_data_%0d", j), 32'(bus.mem_wdata), 32'h100 + j);
    end
    @(negedge iVGA_CLK); #1;
    check("drain_done_we", 32'(bus.mem_we), 0);
    check("drain_done_ready", 32'(bus.wr_ready), 1);
    check("overflow_sticky", 32'(bus.wr_overflow), 1);

    // Full clear with one stalled read, an ignored clr_req and a queued write
    @(negedge iVGA_CLK); bus.clr_req = 1'b1; bus.clr_color = 12'h00F; #1;
    check("clr_busy_same_cycle", 32'(bus.clr_busy), 0);
    @(negedge iVGA_CLK); bus.clr_req = 1'b0; #1;
    check("clr_busy_armed", 32'(bus.clr_busy), 1);
    check("clr_armed_we", 32'(bus.mem_we), 0);
    @(negedge iVGA_CLK); bus.vs_n = 1'b0; #1;
    check("clr_vs_we", 32'(bus.mem_we), 0);
    bad = 0;
    for (int i = 0; i < FB_SIZE; i++) begin
      @(negedge iVGA_CLK);
      bus.vs_n = 1'b1;
      if (i == 2000) begin
        bus.rd_req = 1'b1; bus.rd_addr = 13'd7; #1;
        check("clr_stall_we", 32'(bus.mem_we), 0);
        check("clr_stall_addr", 32'(bus.mem_addr), 7);
        @(negedge iVGA_CLK); bus.rd_req = 1'b0;
      end
      bus.clr_req = (i == 50);
      bus.clr_color = (i == 50) ? 12'hF00 : 12'h00F;
      bus.wr_req = (i == 100); bus.wr_addr = 13'd3; bus.wr_data = 12'h0AA;
      #1;
      if (!(bus.mem_we === 1'b1 && bus.mem_addr === 13'(i) && bus.mem_wdata === 12'h00F)) bad++;
      if (i == FB_SIZE - 1) check("clr_busy_last", 32'(bus.clr_busy), 1);
    end
    check("clr_bad_writes", 32'(bad), 0);
    @(negedge iVGA_CLK); bus.wr_req = 1'b0; bus.clr_req = 1'b0; #1;
    check("clr_busy_fall", 32'(bus.clr_busy), 0);
    check("clr_queued_we", 32'(bus.mem_we), 1);
    check("clr_queued_addr", 32'(bus.mem_addr), 3);
    check("clr_queued_data", 32'(bus.mem_wdata), 32'h0AA);
    @(negedge iVGA_CLK); #1;
    check("clr_after_we", 32'(bus.mem_we), 0);
    check("ram_0", 32'(ram[0]), 32'h00F);
    check("ram_3", 32'(ram[3]), 32'h0AA);
    check("ram_2000", 32'(ram[2000]), 32'h00F);
    check("ram_4799", 32'(ram[4799]), 32'h00F);

    // Reset mid-clear
    @(negedge iVGA_CLK); bus.clr_req = 1'b1; bus.clr_color = 12'h0F0;
    @(negedge iVGA_CLK); bus.clr_req = 1'b0; bus.vs_n = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iVGA_CLK);
      bus.vs_n = 1'b1;
      bus.wr_req = (i == 10); bus.wr_addr = 13'd20; bus.wr_data = 12'h777;
    end
    @(negedge iVGA_CLK); bus.wr_req = 1'b0; #1;
    check("mid_addr", 32'(bus.mem_addr), 1000);
    check("mid_we", 32'(bus.mem_we), 1);
    iRST_n = 1'b0; #1;
    check("mid_rst_we", 32'(bus.mem_we), 0);
    check("mid_rst_busy", 32'(bus.clr_busy), 0);
    check("mid_rst_ready", 32'(bus.wr_ready), 1);
    check("mid_rst_overflow", 32'(bus.wr_overflow), 0);
    @(negedge iVGA_CLK); iRST_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iVGA_CLK);
      bus.vs_n = (i == 5) ? 1'b0 : 1'b1;
      #1;
      if (bus.mem_we !== 1'b0) bad++;
    end
    check("post_rst_writes", 32'(bad), 0);
    check("post_rst_busy", 32'(bus.clr_busy), 0);
    check("ram_999", 32'(ram[999]), 32'h0F0);
    check("ram_1000", 32'(ram[1000]), 32'h00F);
    check("ram_20", 32'(ram[20]), 32'h0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer access arbiter between the VGA scan-out path and the drawing side (keyboard/cursor renderer and clear engine). Display reads always win. Drawing writes are queued in a small FIFO and retired only in cycles the display does not use. A frame-synchronised clear engine fills the whole buffer with one colour. The block owns the RAM's only address/data/write-enable port, clocked by iVGA_CLK.

## Interface
Parameters:
- ADDR_W, 13, frame-buffer address width.
- DATA_W, 12, pixel width (3 × COLOR_WIDTH).
- FB_SIZE, 4800, number of pixel locations (WIDTH/RS × HEIGHT/RS).
- FIFO_DEPTH, 8, write-queue entries; power of two.

Ports:
- iVGA_CLK  in  1  pixel clock; all state on rising edge.
- iRST_n  in  1  reset, asynchronous, active-low.
- vs_n  in  1  vertical sync from sync generator, active-low.
- rd_req  in  1  display read request for this cycle.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  DATA_W  read pixel, equals mem_rdata.
- rd_valid  out  1  rd_data holds the pixel requested the previous cycle.
- wr_req  in  1  push pixel write into queue.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- wr_ready  out  1  queue not full.
- wr_overflow  out  1  sticky: wr_req seen while wr_ready=0.
- clr_req  in  1  one-cycle pulse; start a full-buffer clear.
- clr_color  in  DATA_W  clear colour, sampled with clr_req.
- clr_busy  out  1  clear pending or in progress.
- mem_addr  out  ADDR_W  RAM address (combinational mux).
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency.

## Operation
- Per-cycle priority: display read (rd_req=1) > clear write (state CLEAR) > FIFO drain (queue non-empty and state != CLEAR). Exactly one winner per cycle. If there is no winner: mem_we=0, mem_addr=0.
- Read grant: mem_addr=rd_addr, mem_we=0. rd_valid is registered rd_req.
- FIFO: push on wr_req && wr_ready. Pop when the drain is granted. The head entry drives mem_addr/mem_wdata with mem_we=1.
  - Push and pop in the same cycle: count unchanged.
  - Push while full: dropped and sets wr_overflow.
  - Pop while empty: impossible, because the grant requires non-empty.
- Clear FSM:
  - IDLE: on clr_req, latch clr_color and go to ARMED. clr_busy=1.
  - ARMED: on vs_n=0, clear counter=0 and go to CLEAR.
  - CLEAR: each granted cycle writes clr_color at the counter, then increments it. Display-read cycles stall the counter. After writing FB_SIZE-1, go to IDLE with clr_busy=0 on the next cycle.
  - clr_req while not IDLE is ignored, and clr_color is not re-latched.
- FIFO entries queued before or during a clear retire after the clear completes. They overwrite cleared pixels.
- Counter width is ADDR_W. The terminal compare is against FB_SIZE-1. No wrap past FB_SIZE.
- wr_overflow clears only on reset.
- Asynchronous reset mid-clear abandons the clear. FIFO contents are discarded.

## Timing
- Reset values: rd_valid=0, wr_ready=1, wr_overflow=0, clr_busy=0, FIFO count=0, FSM=IDLE, clear counter=0.
- Outputs driven combinationally from current state and inputs: mem_addr, mem_wdata, mem_we.
- Read latency is 1: rd_req at cycle n gives rd_valid=1 and the data at cycle n+1.
- Write latency:
  - The queue head retires in the first grant cycle after its push cycle, never in the push cycle itself.
  - Minimum push-to-mem_we latency is 1 cycle.
- wr_ready is derived from the registered count and deasserts the cycle after the FIFO_DEPTH-th push.
- clr_busy rises the cycle after clr_req and falls the cycle after the last clear write.
- Clear duration is FB_SIZE cycles plus the number of stalled read cycles.

## Test plan
- Read only: rd_req=1, rd_addr=5, RAM holds 12'hABC -> next cycle rd_valid=1, rd_data=12'hABC; mem_we never asserted.
- Write during reads:
  - Stimulus: push (addr 10, 12'h0F0) while rd_req=1 for 20 cycles.
  - Required: no mem_we for those 20 cycles; after rd_req drops, mem_we=1 with mem_addr=10, mem_wdata=12'h0F0 in the first free cycle.
- FIFO full: with rd_req held high, push 9 writes (depth 8) -> wr_ready=0 after the 8th push; the 9th push is dropped and wr_overflow=1. After release, exactly 8 writes retire in push order.
- Clear: clr_req with clr_color=12'h00F, then vs_n pulse, rd_req=0 -> 4800 consecutive writes of 12'h00F at addresses 0..4799; clr_busy falls the cycle after address 4799.
- Clear vs queue: push a write to addr 3 during CLEAR -> it retires only after the final clear write, so addr 3 ends at the pushed value.
- Reset mid-clear: drop iRST_n at counter 1000 -> mem_we=0, clr_busy=0, FIFO empty immediately; no writes after reset release without a new clr_req.
